// File: rtl/gpu_pkg.sv
// Shared definitions for the framebuffer write path: default geometry,
// the write-entry type and the colour-depth reduction helper.
package gpu_pkg;

  localparam int FB_W_DEF   = 160;
  localparam int FB_H_DEF   = 120;
  localparam int ADDR_W_DEF = 15;

  // One framebuffer write: word address plus RGB565 payload.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [15:0]           data;
  } fb_wr_t;

  // Keep the top bits of each channel: 5 red, 6 green, 5 blue.
  function automatic logic [15:0] rgb888_to_rgb565(input logic [23:0] c);
    return {c[23:19], c[15:10], c[7:3]};
  endfunction

endpackage

// File: rtl/fb_pixel_writer_if.sv
// Framebuffer write port: the writer drives the request, the memory
// answers with ready.
interface fb_pixel_writer_if #(
  parameter int ADDR_W = 15
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ready;

  modport master (output mem_we, output mem_addr, output mem_wdata, input mem_ready);
  modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_ready);
endinterface

// File: rtl/pixel_fifo.sv
// Generic synchronous FIFO. DEPTH must be a power of two and at least 2.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module pixel_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Pixel stream to RGB565 framebuffer writer. Clips off-screen pixels,
// buffers the rest in a FIFO ahead of a single output holding register,
// and signals end-of-shape once everything accepted has been written.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_IDLE    | no end-of-shape outstanding
//   ST_PENDING | in_done seen; waiting for FIFO and output reg to drain
module fb_pixel_writer
  import gpu_pkg::*;
#(
  parameter int FB_W       = FB_W_DEF,
  parameter int FB_H       = FB_H_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                in_px,
  input  logic [7:0]                in_py,
  input  logic [23:0]               in_color,
  input  logic                      in_valid,
  input  logic                      in_done,
  input  logic                      clr_status,
  fb_pixel_writer_if.master         mem,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overflow,
  output logic [15:0]               clip_count
);

  localparam int EW = ADDR_W + 16;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [31:0]       addr_full;
  logic              on_screen;
  logic              clip_ev;
  logic              ovf_ev;
  logic              push;
  logic              pop;
  logic [EW-1:0]     push_data;
  logic [EW-1:0]     fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              out_vld;
  logic [ADDR_W-1:0] out_addr;
  logic [15:0]       out_data;
  logic              xfer;
  logic              drained;
  logic [0:0]        state;

  assign on_screen = (32'(in_px) < 32'(FB_W)) && (32'(in_py) < 32'(FB_H));
  assign addr_full = 32'(in_py) * 32'(FB_W) + 32'(in_px);
  assign push_data = {addr_full[ADDR_W-1:0], rgb888_to_rgb565(in_color)};

  // The output register takes a new entry whenever it is free or emptying.
  assign xfer    = out_vld && mem.mem_ready;
  assign pop     = !fifo_empty && (!out_vld || xfer);
  assign push    = in_valid && on_screen && (!fifo_full || pop);
  assign clip_ev = in_valid && !on_screen;
  assign ovf_ev  = in_valid && on_screen && !push;

  pixel_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Output holding register: address/data only change on a load, so they
  // stay stable for the whole of a stalled write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else if (pop) begin
      out_vld  <= 1'b1;
      out_addr <= fifo_rdata[EW-1:16];
      out_data <= fifo_rdata[15:0];
    end else if (xfer) begin
      out_vld  <= 1'b0;
    end
  end

  assign mem.mem_we    = out_vld;
  assign mem.mem_addr  = out_addr;
  assign mem.mem_wdata = out_data;

  assign drained    = fifo_empty && !out_vld;
  assign frame_done = (state == ST_PENDING) && drained;
  assign busy       = (fifo_count != '0) || out_vld || (state == ST_PENDING);

  // Done tracking; a second in_done while pending folds into the first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (in_done) state <= ST_PENDING;
        ST_PENDING: if (drained) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Sticky status; a drop in the same cycle as a clear takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      clip_count <= '0;
    end else begin
      if (ovf_ev)          overflow <= 1'b1;
      else if (clr_status) overflow <= 1'b0;

      if (clip_ev) begin
        if (clr_status)                  clip_count <= 16'd1;
        else if (clip_count != 16'hFFFF) clip_count <= clip_count + 16'd1;
      end else if (clr_status) begin
        clip_count <= '0;
      end
    end
  end

endmodule
